// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the serializer front end and the sequence detector it feeds.
// Holds the state encodings, the detector pattern and the default word width.
package bit_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Pattern the downstream detector looks for; benches and both stages share it.
  localparam logic [3:0] DETECT_PATTERN = 4'b1101;

  localparam int DEFAULT_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag at LAST.
// Latency: cnt updates on the edge after clr/en; tc is combinational from cnt.
module bit_counter #(
  parameter int            CW   = 4,
  parameter logic [CW-1:0] LAST = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: first bit on w one cycle after the din handshake; din_ready only
// in IDLE or on the final frame cycle so words chain without a bubble. SERIALIZER_PARITY_EN appends an even-parity bit.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_FRAME = CW'(FRAME - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bit_serializer: WIDTH must be in 2..32");
    end
  endgenerate

  state_t           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             w_d, w_q;
  logic             w_valid_d, w_valid_q;
  logic             busy_d, busy_q;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
  logic             parity_d, parity_q;
`endif

  logic [CW-1:0] cnt;
  logic          tc;
  logic          last_cycle;
  logic          take;

  // The counter idles at zero so the first bit of a new word always sees cnt == 0.
  bit_counter #(
    .CW   (CW),
    .LAST (LAST_FRAME)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   ((state_q != SHIFT) || tc),
    .en    (state_q == SHIFT),
    .cnt   (cnt),
    .tc    (tc)
  );

`ifndef SERIALIZER_PARITY_EN
  logic unused_cnt;
  assign unused_cnt = ^cnt;
`endif

  assign last_cycle = (state_q == SHIFT) && tc;
  assign din_ready  = !reset && ((state_q == IDLE) || last_cycle);
  assign take       = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    busy_d    = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif
    if (take) begin
      // First bit goes straight to w; the register keeps the rest, pre-shifted by one.
      state_d   = SHIFT;
      w_d       = MSB_FIRST ? din[WIDTH-1] : din[0];
      shreg_d   = MSB_FIRST ? {din[WIDTH-2:0], 1'b0} : {1'b0, din[WIDTH-1:1]};
      w_valid_d = 1'b1;
      busy_d    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d  = ^din;
`endif
    end else if (state_q == SHIFT && !tc) begin
      w_d       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      w_valid_d = 1'b1;
      busy_d    = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      if (cnt == LAST_DATA) begin
        w_d = parity_q;
      end
`endif
    end else begin
      // End of frame with no follow-on word, plain idle, or a stray encoding.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;

  a_idle_line_low: assert property (@(posedge clk) !w_valid_q |-> !w_q);
  a_busy_tracks_valid: assert property (@(posedge clk) busy_q == w_valid_q);

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance, WIDTH=8.
// Expected bit streams are hand-written per word in emission order.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       w;
  logic       w_valid;
  logic       busy;
  logic [7:0] din_l;
  logic       din_valid_l;
  logic       din_ready_l;
  logic       w_l;
  logic       w_valid_l;
  logic       busy_l;

  int n_checks = 0;
  int n_fail   = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .w         (w),
    .w_valid   (w_valid),
    .busy      (busy)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .reset     (reset),
    .din       (din_l),
    .din_valid (din_valid_l),
    .din_ready (din_ready_l),
    .w         (w_l),
    .w_valid   (w_valid_l),
    .busy      (busy_l)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // seq lists the data bits in the order they must leave, leftmost first; par follows them.
  function automatic logic exp_at(input logic [7:0] seq, input logic par, input int i);
    if (i < 8) return seq[7-i];
    return par;
  endfunction

  task automatic test_reset();
    din_valid = 1'b1;
    din = 8'hFF;
    step();
    step();
    n_checks++;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: w=%b w_valid=%b busy=%b din_ready=%b, required all 0", w, w_valid, busy, din_ready);
    end
    n_checks++;
    if (w_l !== 1'b0 || w_valid_l !== 1'b0 || busy_l !== 1'b0 || din_ready_l !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state_lsb: w=%b w_valid=%b busy=%b din_ready=%b, required all 0", w_l, w_valid_l, busy_l, din_ready_l);
    end
    din_valid = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: din_ready=%b, required 1", din_ready);
    end
  endtask

  task automatic test_single_word();
    din = 8'hD0;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (w !== exp_at(8'b1101_0000, 1'b1, i) || w_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_word bit %0d: w=%b w_valid=%b busy=%b, required w=%b w_valid=1 busy=1",
                 i, w, w_valid, busy, exp_at(8'b1101_0000, 1'b1, i));
      end
      step();
    end
    n_checks++;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_word_idle: w=%b w_valid=%b busy=%b din_ready=%b, required 0 0 0 1", w, w_valid, busy, din_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq;
    int j;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle_ready: din_ready=%b, required 1", din_ready);
    end
    din = 8'hA5;
    din_valid = 1'b1;
    step();
    for (int i = 0; i < 2*FRAME; i++) begin
      seq = (i < FRAME) ? 8'b1010_0101 : 8'b0011_1100;
      j = i % FRAME;
      n_checks++;
      if (w !== exp_at(seq, 1'b0, j) || w_valid !== 1'b1 || din_ready !== (j == FRAME-1)) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: w=%b w_valid=%b din_ready=%b, required w=%b w_valid=1 din_ready=%b",
                 i, w, w_valid, din_ready, exp_at(seq, 1'b0, j), (j == FRAME-1));
      end
      // The second word is presented early; it must only load on the last-bit edge.
      if (i == 0) din = 8'h3C;
      if (i == 2*FRAME-1) din_valid = 1'b0;
      step();
    end
    n_checks++;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_back_idle: w=%b w_valid=%b busy=%b, required all 0", w, w_valid, busy);
    end
  endtask

  task automatic test_lsb_first();
    din_l = 8'h0B;
    din_valid_l = 1'b1;
    step();
    din_valid_l = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (w_l !== exp_at(8'b1101_0000, 1'b1, i) || w_valid_l !== 1'b1) begin
        n_fail++;
        $display("FAIL lsb_first bit %0d: w=%b w_valid=%b, required w=%b w_valid=1",
                 i, w_l, w_valid_l, exp_at(8'b1101_0000, 1'b1, i));
      end
      step();
    end
    n_checks++;
    if (w_l !== 1'b0 || w_valid_l !== 1'b0 || busy_l !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_first_idle: w=%b w_valid=%b busy=%b, required all 0", w_l, w_valid_l, busy_l);
    end
  endtask

  task automatic test_reset_mid_word();
    din = 8'hFF;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (w !== 1'b1 || w_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_pre bit %0d: w=%b w_valid=%b, required 1 1", i, w, w_valid);
      end
      if (i < 3) step();
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: w=%b w_valid=%b busy=%b din_ready=%b, required all 0", w, w_valid, busy, din_ready);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_ready: din_ready=%b, required 1", din_ready);
    end
    din = 8'h81;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (w !== exp_at(8'b1000_0001, 1'b0, i) || w_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_next bit %0d: w=%b w_valid=%b, required w=%b w_valid=1",
                 i, w, w_valid, exp_at(8'b1000_0001, 1'b0, i));
      end
      step();
    end
  endtask

  task automatic test_stall();
    din = 8'hC3;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (w !== exp_at(8'b1100_0011, 1'b0, i) || w_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_first bit %0d: w=%b w_valid=%b, required w=%b w_valid=1",
                 i, w, w_valid, exp_at(8'b1100_0011, 1'b0, i));
      end
      din = 8'hFF;
      step();
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (w !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_gap cycle %0d: w=%b w_valid=%b busy=%b, required all 0", k, w, w_valid, busy);
      end
      if (k == 4) begin
        din = 8'h5A;
        din_valid = 1'b1;
      end
      step();
    end
    din_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      n_checks++;
      if (w !== exp_at(8'b0101_1010, 1'b0, i) || w_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_second bit %0d: w=%b w_valid=%b, required w=%b w_valid=1",
                 i, w, w_valid, exp_at(8'b0101_1010, 1'b0, i));
      end
      step();
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    for (int n = 0; n < 2; n++) begin
      din = (n == 0) ? 8'h07 : 8'h03;
      din_valid = 1'b1;
      step();
      din_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (w !== exp_at(din, (n == 0), i) || w_valid !== 1'b1 || din_ready !== (i == 8)) begin
          n_fail++;
          $display("FAIL parity word %0d bit %0d: w=%b w_valid=%b din_ready=%b, required w=%b w_valid=1 din_ready=%b",
                   n, i, w, w_valid, din_ready, exp_at(din, (n == 0), i), (i == 8));
        end
        step();
      end
      n_checks++;
      if (w_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_frame_end word %0d: w_valid=%b, required 0", n, w_valid);
      end
    end
  endtask
`endif

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    din_l = 8'h00;
    din_valid_l = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_lsb_first();
    test_reset_mid_word();
    step();
    test_stall();
`ifdef SERIALIZER_PARITY_EN
    step();
    test_parity();
`endif
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
